// File: rtl/exc_request_queue.sv
// exc_request_queue: buffers syscall/break/trap requests and presents them one at a time to CP0.
// Define EXC_NEST_EN to allow two-deep nested handlers (inHandler becomes a 2-bit depth).
module exc_request_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
`ifdef EXC_NEST_EN
    , localparam int IH_W = 2
    , localparam int IH_MAX = 2
`else
    , localparam int IH_W = 1
    , localparam int IH_MAX = 1
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sysReq,
    input  logic             bpReq,
    input  logic             trReq,
    input  logic [31:0]      reqPc,
    input  logic             flush,
    input  logic             cop0Busy,
    input  logic             eret,
    input  logic             eJump,
    output logic [4:0]       excCode,
    output logic [31:0]      excPc,
    output logic             excValid,
    output logic             full,
    output logic [IH_W-1:0]  inHandler,
    output logic [CNT_W-1:0] dropCount
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, PRESENT, HANDLER} state_t;
    state_t state, state_nx;
    logic [4:0] code_mem [DEPTH];
    logic [31:0] pc_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count, count_nx;
    logic [IH_W-1:0] depth_nx;
    logic [1:0] n_req;
    logic [2:0] inc;
    logic [CNT_W:0] sum;
    logic any_req, resolve, accept, pop, masked, room, push;
    logic [4:0] req_code;

    assign any_req  = sysReq | bpReq | trReq;
    assign n_req    = 2'(sysReq) + 2'(bpReq) + 2'(trReq);
    assign req_code = sysReq ? 5'd8 : bpReq ? 5'd9 : 5'd13;
    assign resolve  = enable && state == PRESENT && !cop0Busy;
    assign accept   = resolve && eJump;
    // a flushed head is discarded with the rest of the FIFO, so it is neither popped nor counted
    assign pop      = resolve && !flush;
    assign masked   = pop && !eJump;
    assign room     = count != (PW+1)'(DEPTH) || pop;
    assign push     = enable && any_req && !flush && room;
    assign inc      = (enable && !flush) ? 3'(n_req) - 3'(push) + 3'(masked) : 3'd0;
    assign sum      = {1'b0, dropCount} + (CNT_W+1)'(inc);
    assign count_nx = !enable ? count : flush ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
    assign depth_nx = !enable ? inHandler
                    : inHandler + IH_W'(accept) - IH_W'(eret && inHandler != '0);

    always_comb begin
        state_nx = state;
        if (enable)
            state_nx = (count_nx != '0 && depth_nx < IH_W'(IH_MAX)) ? PRESENT
                     : depth_nx != '0 ? HANDLER : IDLE;
    end

    assign excValid = state == PRESENT;
    assign excCode  = excValid ? code_mem[rd_ptr] : 5'd0;
    assign excPc    = excValid ? pc_mem[rd_ptr] : 32'd0;
    assign full     = count == (PW+1)'(DEPTH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inHandler <= '0;
            dropCount <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            inHandler <= depth_nx;
            dropCount <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (enable && flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            code_mem[wr_ptr] <= req_code;
            pc_mem[wr_ptr]   <= reqPc;
        end
    end
endmodule
